// File: rtl/pipeline_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline stall/flush controller.
//   state_t  : controller FSM states (RUN, LU_STALL, MEM_WAIT)
//   action_t : resolved per-cycle pipeline action, drives statistics
//   REG_X0   : architectural zero register (never a hazard source)
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ADVANCE = 2'd0,
    STALL   = 2'd1,
    FREEZE  = 2'd2,
    FLUSH   = 2'd3
  } action_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // True when a source operand that is actually read matches a non-x0 destination.
  function automatic logic src_conflict(input logic       uses,
                                        input logic [4:0] src,
                                        input logic [4:0] rd);
    return uses && (src == rd) && (rd != REG_X0);
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   i_clock  : system clock, rising edge
//   i_reset  : asynchronous active-low reset, clears the count
//   i_inc    : add one this cycle (ignored once saturated)
//   i_clear  : synchronous clear, priority over i_inc
//   o_count  : current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
// Central sequencer for PC / IF-ID / ID-EX / EX-MEM load and flush controls
// of the 5-stage core. Resolves one action per cycle with the priority
//   memory wait (freeze) > taken branch (flush) > load-use (bubble) > advance
// and keeps saturating statistics of stalled cycles and branch flushes.
//
// Parameters
//   LU_CYCLES : bubbles per load-use hazard (1..3)
//   CNT_W     : statistics counter width
// Ports
//   i_clock, i_reset (async, active-low)
//   i_id_rs1/i_id_rs2, i_id_uses_rs1/i_id_uses_rs2 : ID source operands
//   i_ex_rd, i_ex_mem_re                          : ID/EX destination, is-load
//   i_ex_branch_taken                             : EX resolved a taken branch
//   i_dmem_req, i_dmem_ready                      : MEM stage handshake
//   o_pc_load, o_if_id_load, o_if_id_flush        : front-end controls
//   o_id_ex_load, o_id_ex_bubble, o_ex_mem_load   : back-end controls
//   o_stall_cycles, o_flush_count                 : saturating statistics
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_CYCLES = 1,
  parameter int CNT_W     = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_re,
  input  logic             i_ex_branch_taken,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_pc_load,
  output logic             o_if_id_load,
  output logic             o_if_id_flush,
  output logic             o_id_ex_load,
  output logic             o_id_ex_bubble,
  output logic             o_ex_mem_load,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);

  // Bubbles still owed after the first one of a hazard.
  localparam logic [1:0] LU_REMAIN = 2'(LU_CYCLES - 1);

  state_t     r_state;
  state_t     r_ret_state;
  logic [1:0] r_lu_cnt;

  state_t     w_eff_state;
  logic       w_lu_hazard;
  logic       w_mem_wait;
  action_t    w_action;
  logic       w_pc_load;
  logic       w_if_id_load;
  logic       w_if_id_flush;
  logic       w_id_ex_load;
  logic       w_id_ex_bubble;
  logic       w_ex_mem_load;
  logic       w_stall_inc;
  logic       w_flush_inc;

  // -------------------------------------------------------------------------
  // Action resolution. While parked in MEM_WAIT the cycle that sees
  // dmem_ready is judged by the state we were in when the freeze began,
  // so a pending load-use bubble resumes exactly where it left off.
  // -------------------------------------------------------------------------
  always_comb begin
    w_eff_state = (r_state == MEM_WAIT) ? r_ret_state : r_state;
    w_mem_wait  = i_dmem_req && !i_dmem_ready;
    w_lu_hazard = i_ex_mem_re &&
                  (src_conflict(i_id_uses_rs1, i_id_rs1, i_ex_rd) ||
                   src_conflict(i_id_uses_rs2, i_id_rs2, i_ex_rd));

    w_action = ADVANCE;
    if (w_mem_wait) begin
      w_action = FREEZE;
    end else if (i_ex_branch_taken) begin
      w_action = FLUSH;
    end else if ((w_eff_state == LU_STALL) || w_lu_hazard) begin
      w_action = STALL;
    end
  end

  always_comb begin
    w_pc_load      = (w_action == ADVANCE) || (w_action == FLUSH);
    w_if_id_load   = w_pc_load;
    w_if_id_flush  = (w_action == FLUSH);
    w_id_ex_load   = (w_action != FREEZE);
    w_id_ex_bubble = (w_action == STALL) || (w_action == FLUSH);
    w_ex_mem_load  = (w_action != FREEZE);
    w_stall_inc    = (w_action == STALL) || (w_action == FREEZE);
    w_flush_inc    = (w_action == FLUSH);
  end

  // Outputs are gated by reset level so the pipeline freezes the instant
  // reset asserts, not at the next clock edge.
  assign o_pc_load      = w_pc_load      && i_reset;
  assign o_if_id_load   = w_if_id_load   && i_reset;
  assign o_if_id_flush  = w_if_id_flush  && i_reset;
  assign o_id_ex_load   = w_id_ex_load   && i_reset;
  assign o_id_ex_bubble = w_id_ex_bubble && i_reset;
  assign o_ex_mem_load  = w_ex_mem_load  && i_reset;

  // -------------------------------------------------------------------------
  // Controller FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= RUN;
      r_ret_state <= RUN;
      r_lu_cnt    <= 2'd0;
    end else begin
      case (w_action)
        FREEZE: begin
          // Re-entering the wait from MEM_WAIT must keep the original return state.
          if (r_state != MEM_WAIT) begin
            r_ret_state <= r_state;
          end
          r_state <= MEM_WAIT;
        end
        FLUSH: begin
          r_state  <= RUN;
          r_lu_cnt <= 2'd0;
        end
        STALL: begin
          if (w_eff_state == LU_STALL) begin
            r_lu_cnt <= r_lu_cnt - 2'd1;
            r_state  <= (r_lu_cnt == 2'd1) ? RUN : LU_STALL;
          end else if (LU_CYCLES > 1) begin
            r_state  <= LU_STALL;
            r_lu_cnt <= LU_REMAIN;
          end else begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (w_stall_inc),
    .i_clear (1'b0),
    .o_count (o_stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (w_flush_inc),
    .i_clear (1'b0),
    .o_count (o_flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
// Three controller instances share one stimulus stream:
//   inst0 LU_CYCLES=1 CNT_W=16, inst1 LU_CYCLES=2 CNT_W=4, inst2 LU_CYCLES=3 CNT_W=8
// Controls are packed as {pc, if_id, if_id_flush, id_ex, id_ex_bubble, ex_mem}.
// The reference model tracks only "bubbles still owed" and event counts.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

  localparam logic [5:0] CTL_RUN    = 6'b110101;
  localparam logic [5:0] CTL_STALL  = 6'b000111;
  localparam logic [5:0] CTL_FLUSH  = 6'b111111;
  localparam logic [5:0] CTL_FREEZE = 6'b000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       use1, use2, mem_re, br, dreq, drdy;

  logic [5:0]  ctl  [3];
  logic [15:0] scnt [3];
  logic [15:0] fcnt [3];

  int checks = 0;
  int failures = 0;

  // reference model state
  int debt [3];
  int m_s  [3];
  int m_f  [3];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int LU = gi + 1;
      localparam int W  = (gi == 0) ? 16 : ((gi == 1) ? 4 : 8);
      logic [W-1:0] sc, fc;
      logic pc_l, ifid_l, ifid_f, idex_l, idex_b, exmem_l;

      pipeline_stall_ctrl #(.LU_CYCLES(LU), .CNT_W(W)) u_dut (
        .i_clock           (clk),
        .i_reset           (rst_n),
        .i_id_rs1          (id_rs1),
        .i_id_rs2          (id_rs2),
        .i_id_uses_rs1     (use1),
        .i_id_uses_rs2     (use2),
        .i_ex_rd           (ex_rd),
        .i_ex_mem_re       (mem_re),
        .i_ex_branch_taken (br),
        .i_dmem_req        (dreq),
        .i_dmem_ready      (drdy),
        .o_pc_load         (pc_l),
        .o_if_id_load      (ifid_l),
        .o_if_id_flush     (ifid_f),
        .o_id_ex_load      (idex_l),
        .o_id_ex_bubble    (idex_b),
        .o_ex_mem_load     (exmem_l),
        .o_stall_cycles    (sc),
        .o_flush_count     (fc)
      );

      assign ctl[gi]  = {pc_l, ifid_l, ifid_f, idex_l, idex_b, exmem_l};
      assign scnt[gi] = 16'(sc);
      assign fcnt[gi] = 16'(fc);
    end
  endgenerate

  // ---------------- reference model ----------------
  function automatic int lu_of(input int k);
    return k + 1;
  endfunction

  function automatic int max_of(input int k);
    return (k == 0) ? 65535 : ((k == 1) ? 15 : 255);
  endfunction

  function automatic logic hazard_now();
    return mem_re && (ex_rd != 5'd0) &&
           ((use1 && id_rs1 == ex_rd) || (use2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [5:0] model_ctl(input int k);
    if (!rst_n) return CTL_FREEZE;
    if (dreq && !drdy) return CTL_FREEZE;
    if (br) return CTL_FLUSH;
    if (debt[k] > 0 || hazard_now()) return CTL_STALL;
    return CTL_RUN;
  endfunction

  // Advance one clock edge and update the model with the inputs seen there.
  task automatic tick();
    logic hz;
    @(posedge clk);
    hz = hazard_now();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        debt[k] = 0; m_s[k] = 0; m_f[k] = 0;
      end else if (dreq && !drdy) begin
        if (m_s[k] < max_of(k)) m_s[k] = m_s[k] + 1;
      end else if (br) begin
        debt[k] = 0;
        if (m_f[k] < max_of(k)) m_f[k] = m_f[k] + 1;
      end else if (debt[k] > 0) begin
        debt[k] = debt[k] - 1;
        if (m_s[k] < max_of(k)) m_s[k] = m_s[k] + 1;
      end else if (hz) begin
        debt[k] = lu_of(k) - 1;
        if (m_s[k] < max_of(k)) m_s[k] = m_s[k] + 1;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    use1 = 1'b0; use2 = 1'b0; mem_re = 1'b0; br = 1'b0;
    dreq = 1'b0; drdy = 1'b0;
  endtask

  task automatic set_hazard();
    mem_re = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; use1 = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_FREEZE) begin
        failures++; $display("FAIL reset_ctl inst%0d got=%b exp=%b", k, ctl[k], CTL_FREEZE);
      end
      checks++;
      if (scnt[k] !== 16'd0 || fcnt[k] !== 16'd0) begin
        failures++; $display("FAIL reset_cnt inst%0d got=%0d/%0d exp=0/0", k, scnt[k], fcnt[k]);
      end
    end
    tick();
    tick();
    rst_n = 1'b1;
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_RUN) begin
        failures++; $display("FAIL reset_release inst%0d got=%b exp=%b", k, ctl[k], CTL_RUN);
      end
    end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    set_hazard();
    #3;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ctl[k] !== CTL_STALL) begin
        failures++; $display("FAIL lu_first inst%0d got=%b exp=%b", k, ctl[k], CTL_STALL);
      end
    end
    tick();
    mem_re = 1'b0;
    #3;
    checks++;
    if (ctl[0] !== CTL_RUN) begin
      failures++; $display("FAIL lu1_resume got=%b exp=%b", ctl[0], CTL_RUN);
    end
    checks++;
    if (scnt[0] !== 16'd1) begin
      failures++; $display("FAIL lu1_count got=%0d exp=1", scnt[0]);
    end
    checks++;
    if (ctl[1] !== CTL_STALL) begin
      failures++; $display("FAIL lu2_second got=%b exp=%b", ctl[1], CTL_STALL);
    end
    tick();
    #3;
    checks++;
    if (ctl[1] !== CTL_RUN) begin
      failures++; $display("FAIL lu2_resume got=%b exp=%b", ctl[1], CTL_RUN);
    end
    checks++;
    if (scnt[1] !== 16'd2) begin
      failures++; $display("FAIL lu2_count got=%0d exp=2", scnt[1]);
    end
    tick();
    clear_inputs();
    mem_re = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; use1 = 1'b1;
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_RUN) begin
        failures++; $display("FAIL x0_no_hazard inst%0d got=%b exp=%b", k, ctl[k], CTL_RUN);
      end
    end
    tick();
    ex_rd = 5'd5; id_rs1 = 5'd5; use1 = 1'b0; id_rs2 = 5'd3; use2 = 1'b1;
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_RUN) begin
        failures++; $display("FAIL unused_src inst%0d got=%b exp=%b", k, ctl[k], CTL_RUN);
      end
    end
    tick();
    id_rs2 = 5'd5;
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_STALL) begin
        failures++; $display("FAIL rs2_hazard inst%0d got=%b exp=%b", k, ctl[k], CTL_STALL);
      end
    end
    tick();
    clear_inputs();
    $display("test_load_use done");
  endtask

  task automatic test_mem_wait();
    do_reset();
    set_hazard();
    #3;
    checks++;
    if (ctl[1] !== CTL_STALL) begin
      failures++; $display("FAIL mw_pre_stall got=%b exp=%b", ctl[1], CTL_STALL);
    end
    tick();
    clear_inputs();
    dreq = 1'b1; drdy = 1'b0;
    repeat (3) begin
      #3;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ctl[k] !== CTL_FREEZE) begin
          failures++; $display("FAIL mw_freeze inst%0d got=%b exp=%b", k, ctl[k], CTL_FREEZE);
        end
      end
      tick();
    end
    drdy = 1'b1;
    #3;
    checks++;
    if (ctl[1] !== CTL_STALL) begin
      failures++; $display("FAIL mw_resume_bubble got=%b exp=%b", ctl[1], CTL_STALL);
    end
    checks++;
    if (ctl[0] !== CTL_RUN) begin
      failures++; $display("FAIL mw_resume_run got=%b exp=%b", ctl[0], CTL_RUN);
    end
    checks++;
    if (scnt[1] !== 16'd4) begin
      failures++; $display("FAIL mw_count_mid got=%0d exp=4", scnt[1]);
    end
    tick();
    dreq = 1'b0; drdy = 1'b0;
    #3;
    checks++;
    if (ctl[1] !== CTL_RUN) begin
      failures++; $display("FAIL mw_after got=%b exp=%b", ctl[1], CTL_RUN);
    end
    checks++;
    if (scnt[1] !== 16'd5) begin
      failures++; $display("FAIL mw_count got=%0d exp=5", scnt[1]);
    end
    tick();
    $display("test_mem_wait done");
  endtask

  task automatic test_branch();
    do_reset();
    set_hazard();
    br = 1'b1;
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_FLUSH) begin
        failures++; $display("FAIL br_over_lu inst%0d got=%b exp=%b", k, ctl[k], CTL_FLUSH);
      end
    end
    tick();
    clear_inputs();
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_RUN || fcnt[k] !== 16'd1 || scnt[k] !== 16'd0) begin
        failures++; $display("FAIL br_after inst%0d got=%b f=%0d s=%0d exp=%b f=1 s=0",
                             k, ctl[k], fcnt[k], scnt[k], CTL_RUN);
      end
    end
    tick();
    set_hazard();
    #3;
    tick();
    clear_inputs();
    br = 1'b1;
    #3;
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_FLUSH) begin
        failures++; $display("FAIL br_abort inst%0d got=%b exp=%b", k, ctl[k], CTL_FLUSH);
      end
    end
    tick();
    br = 1'b0;
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_RUN || fcnt[k] !== 16'd2) begin
        failures++; $display("FAIL br_abort_after inst%0d got=%b f=%0d exp=%b f=2",
                             k, ctl[k], fcnt[k], CTL_RUN);
      end
    end
    tick();
    br = 1'b1; dreq = 1'b1; drdy = 1'b0;
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_FREEZE) begin
        failures++; $display("FAIL br_freeze inst%0d got=%b exp=%b", k, ctl[k], CTL_FREEZE);
      end
    end
    tick();
    drdy = 1'b1;
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_FLUSH) begin
        failures++; $display("FAIL br_release inst%0d got=%b exp=%b", k, ctl[k], CTL_FLUSH);
      end
    end
    tick();
    clear_inputs();
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fcnt[k] !== 16'd3 || scnt[k] !== 16'd2) begin
        failures++; $display("FAIL br_counts inst%0d got f=%0d s=%0d exp f=3 s=2",
                             k, fcnt[k], scnt[k]);
      end
    end
    tick();
    $display("test_branch done");
  endtask

  task automatic test_saturation();
    do_reset();
    dreq = 1'b1; drdy = 1'b0;
    repeat (20) tick();
    clear_inputs();
    #3;
    checks++;
    if (scnt[1] !== 16'd15) begin
      failures++; $display("FAIL sat_stall_w4 got=%0d exp=15", scnt[1]);
    end
    checks++;
    if (scnt[0] !== 16'd20 || scnt[2] !== 16'd20) begin
      failures++; $display("FAIL sat_stall_wide got=%0d/%0d exp=20/20", scnt[0], scnt[2]);
    end
    tick();
    br = 1'b1;
    repeat (20) tick();
    br = 1'b0;
    #3;
    checks++;
    if (fcnt[1] !== 16'd15 || fcnt[0] !== 16'd20) begin
      failures++; $display("FAIL sat_flush got=%0d/%0d exp=15/20", fcnt[1], fcnt[0]);
    end
    tick();
    $display("test_saturation done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_hazard();
    tick();
    clear_inputs();
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_FREEZE || scnt[k] !== 16'd0) begin
        failures++; $display("FAIL rst_mid_lu inst%0d got=%b s=%0d exp=%b s=0",
                             k, ctl[k], scnt[k], CTL_FREEZE);
      end
    end
    tick();
    rst_n = 1'b1;
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_RUN) begin
        failures++; $display("FAIL rst_mid_lu_release inst%0d got=%b exp=%b", k, ctl[k], CTL_RUN);
      end
    end
    tick();
    dreq = 1'b1; drdy = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_FREEZE || scnt[k] !== 16'd0) begin
        failures++; $display("FAIL rst_mid_mw inst%0d got=%b s=%0d exp=%b s=0",
                             k, ctl[k], scnt[k], CTL_FREEZE);
      end
    end
    tick();
    rst_n = 1'b1;
    clear_inputs();
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ctl[k] !== CTL_RUN) begin
        failures++; $display("FAIL rst_mid_mw_release inst%0d got=%b exp=%b", k, ctl[k], CTL_RUN);
      end
    end
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [5:0] exp_ctl;
    int exp_s, exp_f;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      ex_rd  = 5'($urandom_range(0, 3));
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      use1   = 1'($urandom_range(0, 1));
      use2   = 1'($urandom_range(0, 1));
      mem_re = 1'($urandom_range(0, 1));
      br     = ($urandom_range(0, 7) == 0);
      dreq   = ($urandom_range(0, 2) == 0);
      drdy   = 1'($urandom_range(0, 1));
      rst_n  = ($urandom_range(0, 63) != 0);
      #3;
      for (int k = 0; k < 3; k++) begin
        exp_ctl = model_ctl(k);
        exp_s = rst_n ? m_s[k] : 0;
        exp_f = rst_n ? m_f[k] : 0;
        checks++;
        if (ctl[k] !== exp_ctl) begin
          failures++; $display("FAIL rand_ctl n=%0d inst%0d got=%b exp=%b", n, k, ctl[k], exp_ctl);
        end
        checks++;
        if (scnt[k] !== 16'(exp_s) || fcnt[k] !== 16'(exp_f)) begin
          failures++; $display("FAIL rand_cnt n=%0d inst%0d got s=%0d f=%0d exp s=%0d f=%0d",
                               n, k, scnt[k], fcnt[k], exp_s, exp_f);
        end
      end
      $display("txn %0d rst_n=%b br=%b mw=%b hz=%b ctl=%b/%b/%b", n, rst_n, br,
               dreq && !drdy, hazard_now(), ctl[0], ctl[1], ctl[2]);
      tick();
    end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      debt[k] = 0; m_s[k] = 0; m_f[k] = 0;
    end
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
